// File: rtl/alu_result_buffer.sv
// alu_result_buffer: result/flag capture FIFO placed directly after the ALU.
// It takes ALU results over a valid/ready handshake so writeback can stall
// without stalling the ALU. It also keeps a sticky overflow flag and a
// saturating count of accepted results.
module alu_result_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int CNT_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_result,
  input  logic              in_overflow,
  input  logic              in_zero,
  input  logic              in_negative,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic              out_overflow,
  output logic              out_zero,
  output logic              out_negative,
  input  logic              clear_sticky,
  output logic              sticky_overflow,
  output logic [CNT_W-1:0]  count,
  output logic [PTR_W:0]    level
);

  localparam logic [PTR_W:0]   LEVEL_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   LEVEL_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  // Each entry is {result[31:0], overflow, zero, negative}.
  logic [34:0]      mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [34:0]      head;
  logic             push;
  logic             pop;

  // Ready/valid depend only on occupancy, so a full buffer never accepts,
  // even when the consumer pops in the same cycle.
  assign in_ready  = (level != LEVEL_FULL);
  assign out_valid = (level != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // The head entry is masked to zero while the buffer is empty, so the
  // storage itself never needs a reset.
  assign head         = mem[rd_ptr];
  assign out_result   = out_valid ? head[34:3] : 32'h0;
  assign out_overflow = out_valid & head[2];
  assign out_zero     = out_valid & head[1];
  assign out_negative = out_valid & head[0];

  // Entry storage: write the incoming word and its flags at the write pointer.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= {in_result, in_overflow, in_zero, in_negative};
    end
  end

  // Pointers wrap naturally at DEPTH; level tracks occupancy from push/pop.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   level <= level + LEVEL_ONE;
        2'b01:   level <= level - LEVEL_ONE;
        default: level <= level;
      endcase
    end
  end

  // Sticky overflow: an accepted overflow sets it and beats a simultaneous clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      sticky_overflow <= 1'b0;
    end else if (push && in_overflow) begin
      sticky_overflow <= 1'b1;
    end else if (clear_sticky) begin
      sticky_overflow <= 1'b0;
    end
  end

  // Accepted-result counter saturates at all-ones instead of wrapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (push && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end
  end

endmodule
